// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation station.
package rs_pkg;

  // Every entry carries two source operands.
  localparam int NUM_SRCS     = 2;

  // Field widths of the stored entry. The top-level parameters default to
  // these values and must stay in step with them.
  localparam int RS_DATA_W    = 32;
  localparam int RS_ROBID_W   = 5;
  localparam int RS_CTRL_W    = 8;
  localparam int RS_NUM_LANES = 4;

  // Ceiling log2 that is usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // One reservation station slot.
  typedef struct packed {
    logic                                  valid;
    logic [RS_ROBID_W-1:0]                 robid;
    logic [NUM_SRCS-1:0]                   src_rdy;
    logic [NUM_SRCS-1:0][RS_ROBID_W-1:0]   src_tag;
    logic [NUM_SRCS-1:0][RS_DATA_W-1:0]    src_data;
    logic                                  use_imm;
    logic [RS_DATA_W-1:0]                  imm;
    logic [RS_NUM_LANES-1:0]               lane_mask;
    logic [RS_CTRL_W-1:0]                  ctrl;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix shared by all dispatch lanes. older_q[i][j] = 1 means entry i
// is older than entry j. One matrix state feeds one oldest-select port per
// lane; lanes are chained so a lower lane's pick is hidden from higher lanes.
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_LANES   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [ISSUE_WIDTH-1:0][NUM_ENTRIES-1:0]  alloc,
  input  logic [NUM_ENTRIES-1:0]                   free,
  input  logic [NUM_LANES-1:0][NUM_ENTRIES-1:0]    req,
  output logic [NUM_LANES-1:0][NUM_ENTRIES-1:0]    grant
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q;
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_next;
  logic [NUM_ENTRIES-1:0]                  alloc_any;
  int                                      alloc_slot [NUM_ENTRIES];

  // Collapse the per-slot allocation onehots into a per-entry slot index.
  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      alloc_any[e]  = 1'b0;
      alloc_slot[e] = 0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (alloc[s][e]) begin
          alloc_any[e]  = 1'b1;
          alloc_slot[e] = s;
        end
      end
    end
  end

  // New entries are younger than everything already present; inside one
  // group the lower slot is older. Freed entries drop their ordering bits.
  always_comb begin
    older_next = older_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (i == j)
          older_next[i][j] = 1'b0;
        else if (alloc_any[i] && alloc_any[j])
          older_next[i][j] = (alloc_slot[i] < alloc_slot[j]);
        else if (alloc_any[j])
          older_next[i][j] = 1'b1;
        else if (alloc_any[i])
          older_next[i][j] = 1'b0;
        else if (free[i] || free[j])
          older_next[i][j] = 1'b0;
      end
    end
  end

  // Matrix state; cleared by reset and by flush.
  always_ff @(posedge clk) begin
    if (rst || flush) older_q <= '0;
    else              older_q <= older_next;
  end

  // Per-lane oldest select: a request wins when no other still-available
  // request is older than it.
  always_comb begin
    logic [NUM_ENTRIES-1:0] taken;
    logic                   blocked;
    taken   = '0;
    blocked = 1'b0;
    grant   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        blocked = 1'b0;
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (j != i && req[l][j] && !taken[j] && older_q[j][i]) blocked = 1'b1;
        end
        grant[l][i] = req[l][i] && !taken[i] && !blocked;
      end
      taken = taken | grant[l];
    end
  end

endmodule

// File: rtl/rs_wakeup_select.sv
// Centralised reservation station: accepts renamed issue groups, captures
// operands from the CDB, and dispatches the oldest ready entry per lane
// through registered outputs.
module rs_wakeup_select
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_LANES   = RS_NUM_LANES,
  parameter int NUM_CDB     = 2,
  parameter int DATA_W      = RS_DATA_W,
  parameter int ROBID_W     = RS_ROBID_W,
  parameter int CTRL_W      = RS_CTRL_W,
  localparam int OCC_W      = clog2(NUM_ENTRIES) + 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               flush,
  input  logic [ISSUE_WIDTH-1:0]                             iss_val,
  output logic                                               iss_ready,
  input  logic [ISSUE_WIDTH-1:0][ROBID_W-1:0]                iss_robid,
  input  logic [ISSUE_WIDTH-1:0][NUM_SRCS-1:0]               iss_src_rdy,
  input  logic [ISSUE_WIDTH-1:0][NUM_SRCS-1:0][ROBID_W-1:0]  iss_src_tag,
  input  logic [ISSUE_WIDTH-1:0][NUM_SRCS-1:0][DATA_W-1:0]   iss_src_data,
  input  logic [ISSUE_WIDTH-1:0]                             iss_use_imm,
  input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]                 iss_imm,
  input  logic [ISSUE_WIDTH-1:0][NUM_LANES-1:0]              iss_lane_mask,
  input  logic [ISSUE_WIDTH-1:0][CTRL_W-1:0]                 iss_ctrl,
  input  logic [NUM_CDB-1:0]                                 cdb_val,
  input  logic [NUM_CDB-1:0][ROBID_W-1:0]                    cdb_robid,
  input  logic [NUM_CDB-1:0][DATA_W-1:0]                     cdb_data,
  input  logic [NUM_LANES-1:0]                               lane_free,
  output logic [NUM_LANES-1:0]                               disp_val,
  output logic [NUM_LANES-1:0][DATA_W-1:0]                   disp_src1,
  output logic [NUM_LANES-1:0][DATA_W-1:0]                   disp_src2,
  output logic [NUM_LANES-1:0][ROBID_W-1:0]                  disp_robid,
  output logic [NUM_LANES-1:0][CTRL_W-1:0]                   disp_ctrl,
  output logic [OCC_W-1:0]                                   occupancy
);

  rs_entry_t ent_q    [NUM_ENTRIES];
  rs_entry_t ent_next [NUM_ENTRIES];
  rs_entry_t slot_ent [ISSUE_WIDTH];
  rs_entry_t sel_ent  [NUM_LANES];

  logic [NUM_ENTRIES-1:0]                  valid_q;
  logic [ISSUE_WIDTH-1:0][NUM_ENTRIES-1:0] alloc_oh;
  logic [NUM_LANES-1:0][NUM_ENTRIES-1:0]   req;
  logic [NUM_LANES-1:0][NUM_ENTRIES-1:0]   grant;
  logic [NUM_ENTRIES-1:0]                  disp_any;
  logic                                    issue_fire;
  int                                      issued_cnt;
  int                                      disp_cnt;
  int                                      occ_sum;

  // Lowest-index CDB port with a matching tag supplies the value.
  function automatic void cdb_lookup(input  logic [ROBID_W-1:0] tag,
                                     output logic               hit,
                                     output logic [DATA_W-1:0]  data);
    hit  = 1'b0;
    data = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_val[c] && cdb_robid[c] == tag) begin
        hit  = 1'b1;
        data = cdb_data[c];
      end
    end
  endfunction

  // Issue acceptance depends on registered occupancy only.
  always_comb begin
    iss_ready  = (NUM_ENTRIES - int'(occupancy)) >= ISSUE_WIDTH;
    issue_fire = iss_ready && !flush && !rst;
    issued_cnt = issue_fire ? $countones(iss_val) : 0;
  end

  // Valid slots are packed onto the lowest free entries in slot order.
  always_comb begin
    int free_rank;
    int slot_rank [ISSUE_WIDTH];
    int vr;
    alloc_oh  = '0;
    free_rank = 0;
    vr        = 0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      slot_rank[s] = vr;
      if (iss_val[s]) vr++;
    end
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      valid_q[e] = ent_q[e].valid;
      if (!ent_q[e].valid) begin
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
          if (issue_fire && iss_val[s] && slot_rank[s] == free_rank)
            alloc_oh[s][e] = 1'b1;
        end
        free_rank++;
      end
    end
  end

  // Build the entry each issue slot would write, bypassing same-cycle CDB results.
  always_comb begin
    logic              hit;
    logic [DATA_W-1:0] hdata;
    hit   = 1'b0;
    hdata = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      slot_ent[s].valid     = 1'b1;
      slot_ent[s].robid     = iss_robid[s];
      slot_ent[s].use_imm   = iss_use_imm[s];
      slot_ent[s].imm       = iss_imm[s];
      slot_ent[s].lane_mask = iss_lane_mask[s];
      slot_ent[s].ctrl      = iss_ctrl[s];
      for (int k = 0; k < NUM_SRCS; k++) begin
        slot_ent[s].src_rdy[k]  = iss_src_rdy[s][k];
        slot_ent[s].src_tag[k]  = iss_src_tag[s][k];
        slot_ent[s].src_data[k] = iss_src_data[s][k];
        if (!iss_src_rdy[s][k]) begin
          cdb_lookup(iss_src_tag[s][k], hit, hdata);
          if (hit) begin
            slot_ent[s].src_rdy[k]  = 1'b1;
            slot_ent[s].src_data[k] = hdata;
          end
        end
      end
    end
  end

  // Eligibility uses registered state, so a freshly written or woken entry
  // can only be picked the following cycle.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        req[l][e] = ent_q[e].valid && (&ent_q[e].src_rdy) &&
                    ent_q[e].lane_mask[l] && lane_free[l];
      end
    end
  end

  rs_age_matrix #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .NUM_LANES   (NUM_LANES)
  ) u_age (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .alloc (alloc_oh),
    .free  (disp_any),
    .req   (req),
    .grant (grant)
  );

  // Merge lane grants per entry and mux the granted entry onto each lane.
  always_comb begin
    disp_any = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      disp_any   = disp_any | grant[l];
      sel_ent[l] = '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (grant[l][e]) sel_ent[l] = ent_q[e];
      end
    end
    disp_cnt = $countones(disp_any);
    occ_sum  = int'(occupancy) + issued_cnt - disp_cnt;
  end

  // Next entry state: wakeup, dispatch invalidation, allocation, then flush.
  always_comb begin
    logic              hit;
    logic [DATA_W-1:0] hdata;
    hit   = 1'b0;
    hdata = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      ent_next[e] = ent_q[e];
      if (ent_q[e].valid) begin
        for (int k = 0; k < NUM_SRCS; k++) begin
          if (!ent_q[e].src_rdy[k]) begin
            cdb_lookup(ent_q[e].src_tag[k], hit, hdata);
            if (hit) begin
              ent_next[e].src_rdy[k]  = 1'b1;
              ent_next[e].src_data[k] = hdata;
            end
          end
        end
      end
      if (disp_any[e]) ent_next[e].valid = 1'b0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (alloc_oh[s][e]) ent_next[e] = slot_ent[s];
      end
      if (rst || flush) ent_next[e].valid = 1'b0;
    end
  end

  // Entry storage; only the valid bits are forced by reset/flush above.
  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_ENTRIES; e++) ent_q[e] <= ent_next[e];
  end

  // Occupancy tracks issued minus dispatched entries.
  always_ff @(posedge clk) begin
    if (rst || flush) occupancy <= '0;
    else              occupancy <= OCC_W'(occ_sum);
  end

  // Registered dispatch ports; data holds when a lane is idle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      disp_val   <= '0;
      disp_src1  <= '0;
      disp_src2  <= '0;
      disp_robid <= '0;
      disp_ctrl  <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        disp_val[l] <= |grant[l];
        if (|grant[l]) begin
          disp_src1[l]  <= sel_ent[l].src_data[0];
          disp_src2[l]  <= sel_ent[l].use_imm ? sel_ent[l].imm : sel_ent[l].src_data[1];
          disp_robid[l] <= sel_ent[l].robid;
          disp_ctrl[l]  <= sel_ent[l].ctrl;
        end
      end
    end
  end

  // Occupancy must stay within the station, and no two CDB ports may carry the same tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_sum >= 0 && occ_sum <= NUM_ENTRIES);
      for (int a = 0; a < NUM_CDB; a++) begin
        for (int b = a + 1; b < NUM_CDB; b++) begin
          assert (!(cdb_val[a] && cdb_val[b] && cdb_robid[a] == cdb_robid[b]));
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed bench for the reservation station.
module tb_rs_wakeup_select;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [1:0]             iss_val;
  logic                   iss_ready;
  logic [1:0][4:0]        iss_robid;
  logic [1:0][1:0]        iss_src_rdy;
  logic [1:0][1:0][4:0]   iss_src_tag;
  logic [1:0][1:0][31:0]  iss_src_data;
  logic [1:0]             iss_use_imm;
  logic [1:0][31:0]       iss_imm;
  logic [1:0][3:0]        iss_lane_mask;
  logic [1:0][7:0]        iss_ctrl;
  logic [1:0]             cdb_val;
  logic [1:0][4:0]        cdb_robid;
  logic [1:0][31:0]       cdb_data;
  logic [3:0]             lane_free;
  logic [3:0]             disp_val;
  logic [3:0][31:0]       disp_src1;
  logic [3:0][31:0]       disp_src2;
  logic [3:0][4:0]        disp_robid;
  logic [3:0][7:0]        disp_ctrl;
  logic [4:0]             occupancy;

  int n_cmp = 0;
  int n_err = 0;

  rs_wakeup_select dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .iss_val       (iss_val),
    .iss_ready     (iss_ready),
    .iss_robid     (iss_robid),
    .iss_src_rdy   (iss_src_rdy),
    .iss_src_tag   (iss_src_tag),
    .iss_src_data  (iss_src_data),
    .iss_use_imm   (iss_use_imm),
    .iss_imm       (iss_imm),
    .iss_lane_mask (iss_lane_mask),
    .iss_ctrl      (iss_ctrl),
    .cdb_val       (cdb_val),
    .cdb_robid     (cdb_robid),
    .cdb_data      (cdb_data),
    .lane_free     (lane_free),
    .disp_val      (disp_val),
    .disp_src1     (disp_src1),
    .disp_src2     (disp_src2),
    .disp_robid    (disp_robid),
    .disp_ctrl     (disp_ctrl),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_iss();
    iss_val       = '0;
    iss_robid     = '0;
    iss_src_rdy   = '0;
    iss_src_tag   = '0;
    iss_src_data  = '0;
    iss_use_imm   = '0;
    iss_imm       = '0;
    iss_lane_mask = '0;
    iss_ctrl      = '0;
  endtask

  task automatic set_slot(input int s, input logic [4:0] robid,
                          input logic r1, input logic [4:0] t1, input logic [31:0] d1,
                          input logic r2, input logic [31:0] d2, input logic [3:0] mask);
    iss_val[s]         = 1'b1;
    iss_robid[s]       = robid;
    iss_src_rdy[s][0]  = r1;
    iss_src_tag[s][0]  = t1;
    iss_src_data[s][0] = d1;
    iss_src_rdy[s][1]  = r2;
    iss_src_tag[s][1]  = 5'd0;
    iss_src_data[s][1] = d2;
    iss_use_imm[s]     = 1'b0;
    iss_imm[s]         = '0;
    iss_lane_mask[s]   = mask;
    iss_ctrl[s]        = {3'b010, robid};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    clear_iss();
    cdb_val = '0; cdb_robid = '0; cdb_data = '0;
    lane_free = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_occ", occupancy, 0);
    chk("rst_val", disp_val, 0);
    chk("rst_ready", iss_ready, 1);
    chk("rst_src1", disp_src1[0], 0);

    // Two ready ops on lane 0 dispatch in age order
    lane_free = 4'b1111;
    set_slot(0, 5'd3, 1'b1, 5'd0, 32'd5, 1'b1, 32'd7, 4'b0001);
    set_slot(1, 5'd4, 1'b1, 5'd0, 32'd5, 1'b1, 32'd7, 4'b0001);
    tick(); clear_iss();
    chk("t1_occ_n", occupancy, 2);
    chk("t1_val_n", disp_val, 0);
    tick();
    chk("t1_val_n1", disp_val, 4'b0001);
    chk("t1_rob_n1", disp_robid[0], 3);
    chk("t1_src1", disp_src1[0], 5);
    chk("t1_src2", disp_src2[0], 7);
    chk("t1_ctrl", disp_ctrl[0], 8'h43);
    chk("t1_occ_n1", occupancy, 1);
    tick();
    chk("t1_val_n2", disp_val, 4'b0001);
    chk("t1_rob_n2", disp_robid[0], 4);
    chk("t1_occ_n2", occupancy, 0);
    tick();
    chk("t1_idle", disp_val, 0);
    chk("t1_hold", disp_robid[0], 4);

    // Wakeup from CDB0
    set_slot(0, 5'd10, 1'b0, 5'd9, 32'd0, 1'b1, 32'd1, 4'b0001);
    tick(); clear_iss();
    tick();
    chk("t2_wait", disp_val, 0);
    chk("t2_occ", occupancy, 1);
    cdb_val[0] = 1'b1; cdb_robid[0] = 5'd9; cdb_data[0] = 32'hDEAD;
    tick();
    cdb_val = '0;
    chk("t2_not_early", disp_val, 0);
    tick();
    chk("t2_val", disp_val, 4'b0001);
    chk("t2_src1", disp_src1[0], 32'hDEAD);
    chk("t2_rob", disp_robid[0], 10);
    chk("t2_occ0", occupancy, 0);

    // Same-cycle bypass from CDB1, plus an immediate op on lane 1
    set_slot(0, 5'd11, 1'b0, 5'd6, 32'd0, 1'b1, 32'd2, 4'b0001);
    set_slot(1, 5'd12, 1'b1, 5'd0, 32'd8, 1'b1, 32'd9, 4'b0010);
    iss_use_imm[1] = 1'b1; iss_imm[1] = 32'h1234;
    cdb_val[1] = 1'b1; cdb_robid[1] = 5'd6; cdb_data[1] = 32'h55;
    tick(); clear_iss();
    cdb_val = '0;
    chk("t3_val_n", disp_val, 0);
    tick();
    chk("t3_val", disp_val, 4'b0011);
    chk("t3_src1", disp_src1[0], 32'h55);
    chk("t3_rob", disp_robid[0], 11);
    chk("t3_imm", disp_src2[1], 32'h1234);
    chk("t3_rob1", disp_robid[1], 12);

    // Fill to 15 entries with all lanes busy
    lane_free = 4'b0000;
    for (int g = 0; g < 7; g++) begin
      set_slot(0, 5'(2 * g),     1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b0001);
      set_slot(1, 5'(2 * g + 1), 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b0001);
      tick();
    end
    clear_iss();
    set_slot(0, 5'd14, 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b0001);
    tick(); clear_iss();
    chk("t4_occ15", occupancy, 15);
    chk("t4_notready", iss_ready, 0);
    set_slot(0, 5'd20, 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b0001);
    set_slot(1, 5'd21, 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b0001);
    tick(); clear_iss();
    chk("t4_dropped", occupancy, 15);
    lane_free = 4'b0001;
    tick();
    lane_free = 4'b0000;
    chk("t4_disp", disp_val, 4'b0001);
    chk("t4_oldest", disp_robid[0], 0);
    chk("t4_occ14", occupancy, 14);
    chk("t4_ready", iss_ready, 1);
    lane_free = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("t4_drain", disp_robid[0], 64'(k));
    end
    lane_free = 4'b0000;
    chk("t4_empty", occupancy, 0);

    // Age-ordered select across lanes with only lanes 0/1 free
    set_slot(0, 5'd1, 1'b1, 5'd0, 32'hA, 1'b1, 32'd0, 4'b1111);
    set_slot(1, 5'd2, 1'b1, 5'd0, 32'hB, 1'b1, 32'd0, 4'b1111);
    tick(); clear_iss();
    set_slot(0, 5'd3, 1'b1, 5'd0, 32'hC, 1'b1, 32'd0, 4'b1111);
    tick(); clear_iss();
    lane_free = 4'b0011;
    tick();
    lane_free = 4'b0000;
    chk("t5_val", disp_val, 4'b0011);
    chk("t5_lane0", disp_robid[0], 1);
    chk("t5_lane1", disp_robid[1], 2);
    chk("t5_src_b", disp_src1[1], 32'hB);
    chk("t5_occ", occupancy, 1);
    lane_free = 4'b1000;
    tick();
    lane_free = 4'b0000;
    chk("t5_c_val", disp_val, 4'b1000);
    chk("t5_c_rob", disp_robid[3], 3);

    // Flush with 8 valid entries and a concurrent issue
    for (int g = 0; g < 4; g++) begin
      set_slot(0, 5'(2 * g),     1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b1111);
      set_slot(1, 5'(2 * g + 1), 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b1111);
      tick();
    end
    chk("t6_occ8", occupancy, 8);
    flush = 1'b1;
    lane_free = 4'b1111;
    set_slot(0, 5'd30, 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b1111);
    set_slot(1, 5'd31, 1'b1, 5'd0, 32'd1, 1'b1, 32'd1, 4'b1111);
    tick();
    flush = 1'b0;
    clear_iss();
    chk("t6_occ0", occupancy, 0);
    chk("t6_val0", disp_val, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_nodisp", disp_val, 0);
    end
    chk("t6_occ_end", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
